btb_2bc: RTL and testbench

- Parametrised branch target buffer for the pipelined CPU, with a per-entry saturating counter (n-bit counter, 2 by default), tag and valid bit.
- IF stage: combinational lookup of predicted next PC.
- ID stage: updates tables on resolved branches and jumps.
- Also counts resolved control-flow instructions and mispredictions for performance measurement.

---
 rtl/btb_pkg.sv | 41 ++++
 rtl/btb_stats.sv | 43 ++++
 rtl/btb_2bc.sv | 111 +++++++++++
 tb/tb_btb_2bc.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared constants and helpers for the branch target buffer: counter
// encodings, saturating arithmetic and PC index/tag split.
package btb_pkg;

  // 2-bit counter encodings (strongly/weakly not-taken, weakly/strongly taken)
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  // Default geometry and the tag width it implies
  localparam int WORD_SIZE_DEF = 16;
  localparam int IDX_BITS_DEF  = 8;
  localparam int TAG_BITS_DEF  = WORD_SIZE_DEF - IDX_BITS_DEF;

  // Helpers work on 32-bit carriers so they serve any width up to 32;
  // callers size-cast the result back to the field width.
  function automatic int tag_bits(input int word_size, input int idx_bits);
    return word_size - idx_bits;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic [31:0] maxv);
    return (v >= maxv) ? maxv : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

  function automatic logic [31:0] pc_idx(input logic [31:0] pc,
                                         input int idx_bits);
    return pc & ((32'd1 << idx_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] pc_tag(input logic [31:0] pc,
                                         input int idx_bits);
    return pc >> idx_bits;
  endfunction

endpackage

// File: rtl/btb_stats.sv
// Performance counters: resolved control-flow instructions and
// mispredictions, both saturating.
module btb_stats
  import btb_pkg::*;
#(
  parameter int STAT_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 id_valid,
  input  logic                 id_branch,
  input  logic                 id_jump,
  input  logic                 id_bcond,
  input  logic                 id_pred_taken,
  output logic [STAT_BITS-1:0] stat_ctrl,
  output logic [STAT_BITS-1:0] stat_mispred
);

  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

  logic ctrl_evt;
  logic mispred_evt;

  // A jump is always taken, so only a not-taken prediction is wrong; target
  // mismatches on a taken hit are deliberately not counted.
  assign ctrl_evt    = id_valid && (id_branch || id_jump);
  assign mispred_evt = ctrl_evt &&
                       (id_jump ? !id_pred_taken : (id_pred_taken != id_bcond));

  // Saturating event counters, cleared by reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_ctrl    <= '0;
      stat_mispred <= '0;
    end else begin
      if (ctrl_evt)
        stat_ctrl <= STAT_BITS'(sat_inc(32'(stat_ctrl), 32'(STAT_MAX)));
      if (mispred_evt)
        stat_mispred <= STAT_BITS'(sat_inc(32'(stat_mispred), 32'(STAT_MAX)));
    end
  end

endmodule

// File: rtl/btb_2bc.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Lookup in IF is purely combinational; ID-stage resolution trains the tables.
module btb_2bc
  import btb_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int IDX_BITS  = 8,
  parameter int CNT_BITS  = 2,
  parameter int CNT_INIT  = 1,
  parameter int STAT_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] if_pc,
  output logic [WORD_SIZE-1:0] if_pred_pc,
  output logic                 if_pred_taken,
  output logic                 if_hit,
  input  logic                 id_valid,
  input  logic [WORD_SIZE-1:0] id_pc,
  input  logic                 id_branch,
  input  logic                 id_jump,
  input  logic                 id_bcond,
  input  logic [WORD_SIZE-1:0] id_target,
  input  logic                 id_pred_taken,
  output logic [STAT_BITS-1:0] stat_ctrl,
  output logic [STAT_BITS-1:0] stat_mispred
);

  localparam int TAG_BITS = tag_bits(WORD_SIZE, IDX_BITS);
  localparam int DEPTH    = 1 << IDX_BITS;

  localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;
  localparam logic [CNT_BITS-1:0] CNT_WEAK_T = CNT_BITS'(1 << (CNT_BITS - 1));
  localparam logic [CNT_BITS-1:0] CNT_RST    = CNT_BITS'(CNT_INIT);

  logic [DEPTH-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_q    [DEPTH];
  logic [WORD_SIZE-1:0] target_q [DEPTH];
  logic [CNT_BITS-1:0]  cnt_q    [DEPTH];

  logic [IDX_BITS-1:0]  if_idx;
  logic [TAG_BITS-1:0]  if_tag;
  logic [IDX_BITS-1:0]  id_idx;
  logic [TAG_BITS-1:0]  id_tag;
  logic                 id_hit;
  logic                 upd;
  logic [CNT_BITS-1:0]  cnt_inc;
  logic [CNT_BITS-1:0]  cnt_dec;

  assign if_idx = IDX_BITS'(pc_idx(32'(if_pc), IDX_BITS));
  assign if_tag = TAG_BITS'(pc_tag(32'(if_pc), IDX_BITS));
  assign id_idx = IDX_BITS'(pc_idx(32'(id_pc), IDX_BITS));
  assign id_tag = TAG_BITS'(pc_tag(32'(id_pc), IDX_BITS));

  // IF lookup reads the registered tables only, so an update landing this
  // cycle becomes visible on the next one (no write-to-read bypass).
  always_comb begin
    if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    if_pred_taken = if_hit && cnt_q[if_idx][CNT_BITS-1];
    if_pred_pc    = if_pred_taken ? target_q[if_idx]
                                  : if_pc + WORD_SIZE'(1);
  end

  assign upd     = id_valid && (id_branch || id_jump);
  assign id_hit  = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
  assign cnt_inc = CNT_BITS'(sat_inc(32'(cnt_q[id_idx]), 32'(CNT_MAX)));
  assign cnt_dec = CNT_BITS'(sat_dec(32'(cnt_q[id_idx])));

  // Table training: jumps (also when flagged as branch) force strongly taken,
  // branch hits train the counter, taken branch misses allocate weakly taken.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_RST;
      end
    end else if (upd) begin
      if (id_jump) begin
        valid_q[id_idx]  <= 1'b1;
        tag_q[id_idx]    <= id_tag;
        target_q[id_idx] <= id_target;
        cnt_q[id_idx]    <= CNT_MAX;
      end else if (id_hit) begin
        target_q[id_idx] <= id_target;
        cnt_q[id_idx]    <= id_bcond ? cnt_inc : cnt_dec;
      end else if (id_bcond) begin
        valid_q[id_idx]  <= 1'b1;
        tag_q[id_idx]    <= id_tag;
        target_q[id_idx] <= id_target;
        cnt_q[id_idx]    <= CNT_WEAK_T;
      end
    end
  end

  btb_stats #(
    .STAT_BITS(STAT_BITS)
  ) u_stats (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_branch    (id_branch),
    .id_jump      (id_jump),
    .id_bcond     (id_bcond),
    .id_pred_taken(id_pred_taken),
    .stat_ctrl    (stat_ctrl),
    .stat_mispred (stat_mispred)
  );

endmodule

// File: tb/tb_btb_2bc.sv
// Bench for btb_2bc: directed vector table, hand-written corner sequences and
// a randomized run against a behavioural model.
module tb_btb_2bc;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] if_pc = '0;
  logic        id_valid = 1'b0, id_branch = 1'b0, id_jump = 1'b0;
  logic        id_bcond = 1'b0, id_pred_taken = 1'b0;
  logic [15:0] id_pc = '0, id_target = '0;

  logic [15:0] if_pred_pc, if_pred_pc2;
  logic        if_pred_taken, if_hit, if_pred_taken2, if_hit2;
  logic [15:0] stat_ctrl, stat_mispred;
  logic [1:0]  stat_ctrl2, stat_mispred2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  btb_2bc dut (
    .clk(clk), .reset_n(reset_n), .if_pc(if_pc),
    .if_pred_pc(if_pred_pc), .if_pred_taken(if_pred_taken), .if_hit(if_hit),
    .id_valid(id_valid), .id_pc(id_pc), .id_branch(id_branch),
    .id_jump(id_jump), .id_bcond(id_bcond), .id_target(id_target),
    .id_pred_taken(id_pred_taken),
    .stat_ctrl(stat_ctrl), .stat_mispred(stat_mispred)
  );

  btb_2bc #(.STAT_BITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .if_pc(if_pc),
    .if_pred_pc(if_pred_pc2), .if_pred_taken(if_pred_taken2), .if_hit(if_hit2),
    .id_valid(id_valid), .id_pc(id_pc), .id_branch(id_branch),
    .id_jump(id_jump), .id_bcond(id_bcond), .id_target(id_target),
    .id_pred_taken(id_pred_taken),
    .stat_ctrl(stat_ctrl2), .stat_mispred(stat_mispred2)
  );

  typedef struct {
    logic        v, br, jp, bc;
    logic [15:0] pc, tgt;
    logic        pt;
    logic [15:0] ipc;
    logic        hit, tk;
    logic [15:0] ppc;
    int          ctrl, mis;
  } vec_t;

  vec_t vec [15];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic br, input logic jp,
                        input logic bc, input logic [15:0] pc,
                        input logic [15:0] tgt, input logic pt);
    id_valid = v; id_branch = br; id_jump = jp; id_bcond = bc;
    id_pc = pc; id_target = tgt; id_pred_taken = pt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_lookup(input string name, input logic hit,
                              input logic tk, input logic [15:0] ppc);
    check({name, " hit"}, if_hit, hit);
    check({name, " taken"}, if_pred_taken, tk);
    check({name, " pred_pc"}, if_pred_pc, ppc);
  endtask

  // Behavioural reference: entry state as plain integers, counter as a number
  bit mv [256];
  int mtag [256];
  int mtgt [256];
  int mcnt [256];
  int mctrl, mmis;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  initial begin
    logic [15:0] pool [6];
    int idx, e_hit, e_tk, e_ppc;

    //         v  br jp bc  id_pc    tgt      pt ifpc     hit tk ppc     ctrl mis
    vec[0]  = '{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0012, 0, 0, 16'h0013, 0, 0};
    vec[1]  = '{1, 0, 1, 0, 16'h0012, 16'h0040, 0, 16'h0012, 1, 1, 16'h0040, 1, 1};
    vec[2]  = '{1, 1, 0, 0, 16'h0030, 16'h0050, 0, 16'h0030, 0, 0, 16'h0031, 2, 1};
    vec[3]  = '{1, 1, 0, 1, 16'h0030, 16'h0050, 0, 16'h0030, 1, 1, 16'h0050, 3, 2};
    vec[4]  = '{1, 1, 0, 0, 16'h0030, 16'h0050, 1, 16'h0030, 1, 0, 16'h0031, 4, 3};
    vec[5]  = '{1, 1, 0, 1, 16'h0030, 16'h0050, 0, 16'h0030, 1, 1, 16'h0050, 5, 4};
    vec[6]  = '{1, 1, 0, 1, 16'h0030, 16'h0050, 1, 16'h0030, 1, 1, 16'h0050, 6, 4};
    vec[7]  = '{1, 1, 0, 0, 16'h0030, 16'h0050, 1, 16'h0030, 1, 1, 16'h0050, 7, 5};
    vec[8]  = '{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0112, 0, 0, 16'h0113, 7, 5};
    vec[9]  = '{1, 1, 0, 1, 16'h0112, 16'h0200, 0, 16'h0112, 1, 1, 16'h0200, 8, 6};
    vec[10] = '{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0012, 0, 0, 16'h0013, 8, 6};
    vec[11] = '{1, 1, 1, 0, 16'h0080, 16'h0090, 1, 16'h0080, 1, 1, 16'h0090, 9, 6};
    vec[12] = '{0, 1, 0, 1, 16'h0060, 16'h0070, 0, 16'h0060, 0, 0, 16'h0061, 9, 6};
    vec[13] = '{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'hFFFF, 0, 0, 16'h0000, 9, 6};
    vec[14] = '{1, 1, 0, 0, 16'h0070, 16'h0080, 1, 16'h0030, 1, 1, 16'h0050, 10, 7};

    do_reset();

    foreach (vec[k]) begin
      @(negedge clk);
      set_id(vec[k].v, vec[k].br, vec[k].jp, vec[k].bc, vec[k].pc,
             vec[k].tgt, vec[k].pt);
      if_pc = vec[k].ipc;
      @(posedge clk);
      #1;
      set_id(0, 0, 0, 0, 16'h0, 16'h0, 0);
      check_lookup($sformatf("vec%0d", k), vec[k].hit, vec[k].tk, vec[k].ppc);
      check($sformatf("vec%0d stat_ctrl", k), stat_ctrl, vec[k].ctrl);
      check($sformatf("vec%0d stat_mispred", k), stat_mispred, vec[k].mis);
    end

    // Same-cycle update and lookup of an index: old contents until next cycle
    @(negedge clk);
    if_pc = 16'h0012;
    set_id(1, 0, 1, 0, 16'h0012, 16'h0040, 0);
    #1;
    check_lookup("samecyc before", 0, 0, 16'h0013);
    @(posedge clk);
    #1;
    set_id(0, 0, 0, 0, 16'h0, 16'h0, 0);
    check_lookup("samecyc after", 1, 1, 16'h0040);
    check("samecyc stat_ctrl", stat_ctrl, 11);

    // Reset mid-operation with an update pending: everything learned is lost
    @(negedge clk);
    reset_n = 1'b0;
    set_id(1, 0, 1, 0, 16'h0012, 16'h0040, 0);
    @(posedge clk);
    #1;
    check_lookup("midreset", 0, 0, 16'h0013);
    check("midreset stat_ctrl", stat_ctrl, 0);
    check("midreset stat_mispred", stat_mispred, 0);
    @(negedge clk);
    set_id(0, 0, 0, 0, 16'h0, 16'h0, 0);
    reset_n = 1'b1;
    if_pc = 16'h0030;
    #1;
    check_lookup("midreset old entry", 0, 0, 16'h0031);

    // Narrow statistics counters saturate instead of wrapping
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      set_id(1, 1, 0, 1, 16'h0070, 16'h0100, 0);
    end
    @(negedge clk);
    set_id(1, 1, 0, 1, 16'h0080, 16'h0123, 1);
    id_valid = 1'b0;
    if_pc = 16'h0080;
    @(posedge clk);
    #1;
    check("sat2 stat_ctrl", stat_ctrl2, 3);
    check("sat2 stat_mispred", stat_mispred2, 3);
    check("sat16 stat_ctrl", stat_ctrl, 5);
    check("sat16 stat_mispred", stat_mispred, 5);
    check_lookup("invalid id", 0, 0, 16'h0081);
    if_pc = 16'h0070;
    #1;
    check_lookup("sat entry", 1, 1, 16'h0100);
    set_id(0, 0, 0, 0, 16'h0, 16'h0, 0);

    // Randomized traffic over a small aliasing PC pool
    pool = '{16'h0010, 16'h0110, 16'h0020, 16'h00FF, 16'hFFFF, 16'h0021};
    do_reset();
    for (int i = 0; i < 256; i++) begin
      mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; mcnt[i] = 1;
    end
    mctrl = 0;
    mmis = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if_pc = pool[$urandom_range(0, 5)];
      set_id($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             pool[$urandom_range(0, 5)], 16'($urandom),
             $urandom_range(0, 1) == 1);
      #1;
      idx = if_pc % 256;
      e_hit = (mv[idx] && mtag[idx] == if_pc / 256) ? 1 : 0;
      e_tk = (e_hit == 1 && mcnt[idx] >= 2) ? 1 : 0;
      e_ppc = (e_tk == 1) ? mtgt[idx] : (int'(if_pc) + 1) % 65536;
      tests++;
      if (if_hit !== 1'(e_hit) || if_pred_taken !== 1'(e_tk) ||
          if_pred_pc !== 16'(e_ppc) || stat_ctrl !== 16'(min_i(mctrl, 65535)) ||
          stat_mispred !== 16'(min_i(mmis, 65535)) ||
          stat_ctrl2 !== 2'(min_i(mctrl, 3)) || stat_mispred2 !== 2'(min_i(mmis, 3))) begin
        fails++;
        $display("FAIL rand cyc%0d pc=%h: got hit=%0d tk=%0d ppc=%h ctrl=%0d mis=%0d ctrl2=%0d mis2=%0d, expected hit=%0d tk=%0d ppc=%h ctrl=%0d mis=%0d",
                 cyc, if_pc, if_hit, if_pred_taken, if_pred_pc, stat_ctrl,
                 stat_mispred, stat_ctrl2, stat_mispred2, e_hit, e_tk, e_ppc,
                 mctrl, mmis);
      end
      @(posedge clk);
      if (id_valid && (id_branch || id_jump)) begin
        idx = id_pc % 256;
        mctrl++;
        if (id_jump) begin
          if (!id_pred_taken) mmis++;
          mv[idx] = 1; mtag[idx] = id_pc / 256; mtgt[idx] = id_target; mcnt[idx] = 3;
        end else begin
          if (id_pred_taken != id_bcond) mmis++;
          if (mv[idx] && mtag[idx] == id_pc / 256) begin
            mtgt[idx] = id_target;
            mcnt[idx] = id_bcond ? min_i(mcnt[idx] + 1, 3)
                                 : ((mcnt[idx] > 0) ? mcnt[idx] - 1 : 0);
          end else if (id_bcond) begin
            mv[idx] = 1; mtag[idx] = id_pc / 256; mtgt[idx] = id_target; mcnt[idx] = 2;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
